// File: rtl/draw_playfield.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | draw_playfield: centred grid playfield (border, fill, blinking food cell)  |
// | with food position changes staged and committed on vblank rising edge.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module draw_playfield #(
   parameter int          HOR_PIX      = 1024,
   parameter int          VER_PIX      = 768,
   parameter int          GRID_SIZE    = 16,
   parameter int          FRAME_X_SIZE = 40,
   parameter int          FRAME_Y_SIZE = 20,
   parameter int          FRAME_WIDTH  = 1,
   parameter int          MODE         = 0,
   parameter int          BLINK_FRAMES = 0,
   parameter logic [11:0] BORDER_RGB   = 12'hf00,
   parameter logic [11:0] BG_RGB       = 12'hfff,
   parameter logic [11:0] ALT_RGB      = 12'h00f,
   parameter logic [11:0] FOOD_RGB     = 12'hff0,
   parameter logic [11:0] OUTSIDE_RGB  = 12'hfff
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic [10:0] hcount_in,
   input  logic [10:0] vcount_in,
   input  logic        hsync_in,
   input  logic        hblnk_in,
   input  logic        vsync_in,
   input  logic        vblnk_in,
   input  logic        food_load,
   input  logic        food_clear,
   input  logic [6:0]  food_x,
   input  logic [5:0]  food_y,
   output logic [10:0] hcount_out,
   output logic [10:0] vcount_out,
   output logic        hsync_out,
   output logic        hblnk_out,
   output logic        vsync_out,
   output logic        vblnk_out,
   output logic [11:0] rgb_out,
   output logic        border,
   output logic [6:0]  food_x_out,
   output logic [5:0]  food_y_out,
   output logic        food_valid_out,
   output logic        food_busy,
   output logic        food_err
);

   localparam int          SH         = $clog2(GRID_SIZE);
   localparam int          X0         = (HOR_PIX - FRAME_X_SIZE * GRID_SIZE) / 2;
   localparam int          Y0         = (VER_PIX - FRAME_Y_SIZE * GRID_SIZE) / 2;
   localparam logic [10:0] X_LO       = 11'(X0);
   localparam logic [10:0] X_HI       = 11'(X0 + FRAME_X_SIZE * GRID_SIZE);
   localparam logic [10:0] Y_LO       = 11'(Y0);
   localparam logic [10:0] Y_HI       = 11'(Y0 + FRAME_Y_SIZE * GRID_SIZE);
   localparam logic [10:0] G_LO       = 11'(FRAME_WIDTH);
   localparam logic [10:0] GX_HI      = 11'(FRAME_X_SIZE - FRAME_WIDTH);
   localparam logic [10:0] GY_HI      = 11'(FRAME_Y_SIZE - FRAME_WIDTH);
   localparam logic [10:0] CELL_MASK  = 11'(GRID_SIZE - 1);
   localparam logic [6:0]  FX_MIN     = 7'(FRAME_WIDTH);
   localparam logic [6:0]  FX_MAX     = 7'(FRAME_X_SIZE - FRAME_WIDTH);
   localparam logic [5:0]  FY_MIN     = 6'(FRAME_WIDTH);
   localparam logic [5:0]  FY_MAX     = 6'(FRAME_Y_SIZE - FRAME_WIDTH);
   localparam int          CW         = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CW-1:0] BLINK_LAST = CW'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);

   logic [10:0] hcount_q, hcount_d, vcount_q, vcount_d;
   logic        hsync_q, hblnk_q, vsync_q, vblnk_q;
   logic [11:0] rgb_q, rgb_d;
   logic        border_q, border_d;
   logic [6:0]  pend_x_q, pend_x_d, food_x_q, food_x_d;
   logic [5:0]  pend_y_q, pend_y_d, food_y_q, food_y_d;
   logic        pend_valid_q, pend_valid_d, pend_flag_q, pend_flag_d;
   logic        food_valid_q, food_valid_d;
   logic        err_q, err_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic        phase_q, phase_d;

   logic [10:0] w_dx, w_dy, w_gx, w_gy;
   logic        w_inside, w_border, w_food, w_alt, w_vedge, w_load_ok;

   // Cell coordinates are only meaningful when w_inside is set.
   always_comb begin
      w_dx     = hcount_in - X_LO;
      w_dy     = vcount_in - Y_LO;
      w_gx     = w_dx >> SH;
      w_gy     = w_dy >> SH;
      w_inside = (hcount_in >= X_LO) && (hcount_in < X_HI) &&
                 (vcount_in >= Y_LO) && (vcount_in < Y_HI);
      w_border = w_inside && ((w_gx < G_LO) || (w_gx >= GX_HI) ||
                              (w_gy < G_LO) || (w_gy >= GY_HI));
      w_food   = food_valid_q && !phase_q &&
                 (w_gx == {4'b0, food_x_q}) && (w_gy == {5'b0, food_y_q});
      if (MODE == 1)
         w_alt = ((w_dx & CELL_MASK) == 11'd0) || ((w_dy & CELL_MASK) == 11'd0);
      else if (MODE == 2)
         w_alt = w_gx[0] ^ w_gy[0];
      else
         w_alt = 1'b0;
   end

   always_comb begin
      hcount_d = hcount_in;
      vcount_d = vcount_in;
      border_d = w_border;
      if (hblnk_in || vblnk_in)
         rgb_d = 12'h000;
      else if (!w_inside)
         rgb_d = OUTSIDE_RGB;
      else if (w_border)
         rgb_d = BORDER_RGB;
      else if (w_food)
         rgb_d = FOOD_RGB;
      else if (w_alt)
         rgb_d = ALT_RGB;
      else
         rgb_d = BG_RGB;
   end

   // Commit is evaluated before the request so a same-cycle request re-stages.
   always_comb begin
      pend_x_d     = pend_x_q;
      pend_y_d     = pend_y_q;
      pend_valid_d = pend_valid_q;
      pend_flag_d  = pend_flag_q;
      food_x_d     = food_x_q;
      food_y_d     = food_y_q;
      food_valid_d = food_valid_q;
      cnt_d        = cnt_q;
      phase_d      = phase_q;
      err_d        = 1'b0;
      w_vedge      = vblnk_in && !vblnk_q;
      w_load_ok    = (food_x >= FX_MIN) && (food_x < FX_MAX) &&
                     (food_y >= FY_MIN) && (food_y < FY_MAX);
      if (w_vedge) begin
         if (pend_flag_q) begin
            food_x_d     = pend_x_q;
            food_y_d     = pend_y_q;
            food_valid_d = pend_valid_q;
            pend_flag_d  = 1'b0;
            cnt_d        = '0;
            phase_d      = 1'b0;
         end else if (BLINK_FRAMES > 0) begin
            if (cnt_q == BLINK_LAST) begin
               cnt_d   = '0;
               phase_d = !phase_q;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      end
      if (food_clear) begin
         pend_valid_d = 1'b0;
         pend_flag_d  = 1'b1;
      end else if (food_load) begin
         if (w_load_ok) begin
            pend_x_d     = food_x;
            pend_y_d     = food_y;
            pend_valid_d = 1'b1;
            pend_flag_d  = 1'b1;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         hcount_q     <= '0;
         vcount_q     <= '0;
         hsync_q      <= 1'b0;
         hblnk_q      <= 1'b0;
         vsync_q      <= 1'b0;
         vblnk_q      <= 1'b0;
         rgb_q        <= '0;
         border_q     <= 1'b0;
         pend_x_q     <= '0;
         pend_y_q     <= '0;
         pend_valid_q <= 1'b0;
         pend_flag_q  <= 1'b0;
         food_x_q     <= '0;
         food_y_q     <= '0;
         food_valid_q <= 1'b0;
         err_q        <= 1'b0;
         cnt_q        <= '0;
         phase_q      <= 1'b0;
      end else begin
         hcount_q     <= hcount_d;
         vcount_q     <= vcount_d;
         hsync_q      <= hsync_in;
         hblnk_q      <= hblnk_in;
         vsync_q      <= vsync_in;
         vblnk_q      <= vblnk_in;
         rgb_q        <= rgb_d;
         border_q     <= border_d;
         pend_x_q     <= pend_x_d;
         pend_y_q     <= pend_y_d;
         pend_valid_q <= pend_valid_d;
         pend_flag_q  <= pend_flag_d;
         food_x_q     <= food_x_d;
         food_y_q     <= food_y_d;
         food_valid_q <= food_valid_d;
         err_q        <= err_d;
         cnt_q        <= cnt_d;
         phase_q      <= phase_d;
      end
   end

   assign hcount_out     = hcount_q;
   assign vcount_out     = vcount_q;
   assign hsync_out      = hsync_q;
   assign hblnk_out      = hblnk_q;
   assign vsync_out      = vsync_q;
   assign vblnk_out      = vblnk_q;
   assign rgb_out        = rgb_q;
   assign border         = border_q;
   assign food_x_out     = food_x_q;
   assign food_y_out     = food_y_q;
   assign food_valid_out = food_valid_q;
   assign food_busy      = pend_flag_q;
   assign food_err       = err_q;

endmodule
`default_nettype wire

// File: doc/draw_playfield.md
# draw_playfield

Parametrised successor to the fixed background drawer, placed in the VGA pipeline directly after the timing generator. It draws a centred, grid-aligned playfield: a border frame, an interior in one of three fill modes, and a single food cell. Food positions are loaded through a small request interface and applied only at the next vertical blank, so the picture never tears. An optional frame-counted blink is applied to the food cell.

## Interface
- HOR_PIX, 1024: active pixels per line
- VER_PIX, 768: active lines
- GRID_SIZE, 16: cell size in pixels; must be a power of two
- FRAME_X_SIZE, 40: frame width in cells, at most 128
- FRAME_Y_SIZE, 20: frame height in cells, at most 64
- FRAME_WIDTH, 1: border thickness in cells, at least 1
- MODE, 0: interior fill; 0 = plain, 1 = grid lines, 2 = checkerboard
- BLINK_FRAMES, 0: frames per blink half-period; 0 disables blinking
- BORDER_RGB 12'hf00, BG_RGB 12'hfff, ALT_RGB 12'h00f, FOOD_RGB 12'hff0, OUTSIDE_RGB 12'hfff: colours
- pclk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- hcount_in, vcount_in  in  11  pixel counters
- hsync_in, hblnk_in, vsync_in, vblnk_in  in  1  timing signals
- food_load  in  1  one-cycle request to stage a new food position
- food_clear  in  1  one-cycle request to stage removal of the food
- food_x  in  7  food column, in cells, relative to the frame origin
- food_y  in  6  food row, in cells, relative to the frame origin
- hcount_out, vcount_out  out  11  delayed counters
- hsync_out, hblnk_out, vsync_out, vblnk_out  out  1  delayed timing signals
- rgb_out  out  12  pixel colour
- border  out  1  high when the output pixel lies on the frame border
- food_x_out, food_y_out  out  7/6  committed food position
- food_valid_out  out  1  high when food is committed and drawn
- food_busy  out  1  high while a staged change awaits vblank
- food_err  out  1  one-cycle pulse when a load is rejected

## Operation
- Frame origin: X0 = (HOR_PIX − FRAME_X_SIZE·GRID_SIZE)/2 and Y0 = (VER_PIX − FRAME_Y_SIZE·GRID_SIZE)/2. With defaults, X0 = 192 and Y0 = 224.
- Relative cell coordinates: gx = (hcount_in − X0)/GRID_SIZE and gy = (vcount_in − Y0)/GRID_SIZE. Both are valid only inside the frame rectangle; the division is a shift.
- Inside the frame rectangle:
  - Border: gx < FRAME_WIDTH, or gx ≥ FRAME_X_SIZE − FRAME_WIDTH, or the same condition for gy.
  - Interior: everything else in the rectangle.
- Colour priority:
  1. hblnk_in or vblnk_in → 0.
  2. Border → BORDER_RGB.
  3. Food cell with blink phase 0 → FOOD_RGB.
  4. Interior fill:
     - MODE 0: BG_RGB.
     - MODE 1: ALT_RGB when the pixel offset within its cell is 0 in x or y; otherwise BG_RGB.
     - MODE 2: ALT_RGB when (gx+gy) is odd; otherwise BG_RGB.
  5. Outside the rectangle → OUTSIDE_RGB.
- Food staging registers: pend_x, pend_y, pend_valid (food present after commit), pend_flag (a change is staged).
- food_load validity: FRAME_WIDTH ≤ food_x < FRAME_X_SIZE − FRAME_WIDTH and FRAME_WIDTH ≤ food_y < FRAME_Y_SIZE − FRAME_WIDTH.
  - Valid load: staging registers take the new position, pend_valid = 1, pend_flag = 1.
  - Invalid load: food_err pulses for one cycle; the staging registers are unchanged.
- food_clear: pend_valid = 0, pend_flag = 1.
- food_load and food_clear in the same cycle: clear wins; food_err is not raised.
- A further request while pend_flag is set overwrites the staged value (last request wins).
- Commit happens on the rising edge of vblnk_in, detected against a registered copy. When pend_flag is set:
  - committed position and valid bit take the staged values;
  - pend_flag clears;
  - the blink counter and blink phase reset to 0.
- A request in the same cycle as a commit edge: the commit uses the old staged value, and the new request becomes staged. food_busy stays high.
- food_busy = pend_flag.
- Blink (BLINK_FRAMES > 0):
  - A frame counter increments on each vblank rising edge.
  - When it reaches BLINK_FRAMES − 1, it wraps to 0 and toggles the phase.
  - With BLINK_FRAMES = 0 the phase is held at 0.

## Timing
- Latency is 1 cycle: every *_out signal, rgb_out and border reflect the inputs of the previous pclk edge.
- food_err is registered and asserts in the cycle after the request.
- food_busy asserts in the cycle after an accepted request. It deasserts in the cycle after the commit edge.
- The committed position affects rgb_out from the first pixel after the commit, i.e. from the next active frame.
- Reset values: every output is 0, including rgb_out, border, food_valid_out, food_busy and food_err. The staged state, blink counter and blink phase are also cleared.
- Reset asserted mid-operation drops any staged change immediately. No commit occurs until a new request arrives.

## Test plan
- Reset, then drive an unblanked pixel at (192,224) → next cycle rgb_out = 12'hf00 and border = 1. Pixel (208,240) → 12'hfff and border = 0.
- Edges: (831,543) → 12'hf00. (832,543) → OUTSIDE_RGB with border = 0. (816,300) → 12'hf00. Any blanked pixel → 0.
- food_load with x = 5, y = 3 mid-frame → food_busy = 1 and pixel (272,272) stays 12'hfff. After the vblnk rising edge → (272,272) = 12'hff0, food_valid_out = 1, food_busy = 0.
- food_load with x = 0 and, separately, x = 39 → food_err pulses once for each; food_busy and the committed state are unchanged. Simultaneous load and clear → food_valid_out = 0 after vblank.
- BLINK_FRAMES = 2 → food is drawn in frames 0–1 after commit, hidden in frames 2–3, drawn in frames 4–5.
- MODE 2: pixels (208,240) and (224,240) → BG_RGB and ALT_RGB respectively. Reset mid-frame with a staged load → all outputs 0 and no later commit.
